// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressable data memory: access sizes and
// the clear/ready controller states.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store word on the
// way in, lane extraction plus sign/zero extension on the way out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  input  logic        load_unsigned,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_value
);

  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign shifted = load_word >> {lane, 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = lane[1] ? load_word[31:16] : load_word[15:0];

  // Replicating the sub-word across all lanes lets the byte enables alone
  // pick which lanes commit.
  always_comb begin
    byte_en    = 4'b0000;
    store_word = store_data;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
      end
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    load_value = load_word;
    case (size)
      SZ_BYTE: load_value = load_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_value = load_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_value = load_word;
    endcase
  end

endmodule

// File: rtl/dmem_subword.sv
// Byte-addressable data memory with sub-word access, registered load port,
// access error strobe and a one-word-per-cycle clear after reset.
module dmem_subword
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              access_err,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      mem_q [DEPTH];
  state_e           state_q, state_d;
  logic [PTR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             read_valid_q, read_valid_d;
  logic             access_err_q, access_err_d;

  logic [IDX_W-1:0] word_idx;
  logic [PTR_W-1:0] mem_idx;
  logic [1:0]       lane;
  size_e            req_size;
  logic             misaligned, out_of_range, req_err;
  logic [31:0]      raw_word, ld_value, st_word;
  logic [3:0]       st_be;

  logic             mem_we;
  logic [PTR_W-1:0] mem_widx;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;

  assign word_idx     = addr[ADDR_W-1:2];
  assign mem_idx      = word_idx[PTR_W-1:0];
  assign lane         = addr[1:0];
  assign req_size     = size_e'(size);
  assign misaligned   = ((req_size == SZ_HALF) && lane[0]) ||
                        ((req_size == SZ_WORD) && (lane != 2'b00));
  assign out_of_range = (32'(word_idx) >= 32'(DEPTH));
  assign req_err      = misaligned || out_of_range || (req_size == SZ_RSVD);
  assign raw_word     = out_of_range ? 32'h0 : mem_q[mem_idx];

  dmem_lane_align u_align (
    .size          (req_size),
    .lane          (lane),
    .store_data    (write_data),
    .load_word     (raw_word),
    .load_unsigned (load_unsigned),
    .byte_en       (st_be),
    .store_word    (st_word),
    .load_value    (ld_value)
  );

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    access_err_d = 1'b0;
    mem_we       = 1'b0;
    mem_widx     = clr_ptr_q;
    mem_be       = 4'b0000;
    mem_wdata    = 32'h0;
    case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_be = 4'b1111;
        if (clr_ptr_q == PTR_W'(DEPTH - 1)) begin
          state_d   = ST_READY;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        if (MemWrite && !req_err) begin
          mem_we    = 1'b1;
          mem_widx  = mem_idx;
          mem_be    = st_be;
          mem_wdata = st_word;
        end
        if (MemRead || MemWrite) access_err_d = req_err;
        // Array is read from the pre-edge contents, so a same-cycle store is
        // not visible to this load.
        if (MemRead) begin
          read_valid_d = 1'b1;
          read_data_d  = req_err ? 32'h0 : ld_value;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      access_err_q <= access_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign access_err = access_err_q;
  assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem_subword.sv
// Directed bench for dmem_subword: clear sequence, sub-word stores/loads,
// extension, error cases, read-before-write and reset during clear.
module tb_dmem_subword;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       write_data = '0;
  logic              MemRead = 1'b0;
  logic              MemWrite = 1'b0;
  logic [1:0]        size = 2'b10;
  logic              load_unsigned = 1'b0;
  logic [31:0]       read_data;
  logic              read_valid;
  logic              access_err;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  dmem_subword #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .addr          (addr),
    .write_data    (write_data),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .size          (size),
    .load_unsigned (load_unsigned),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .access_err    (access_err),
    .busy          (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] a;
    logic [31:0]       wd;
    logic              rd;
    logic              wr;
    logic [1:0]        sz;
    logic              uns;
    logic              exp_err;
    logic [31:0]       exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic exp_err, input logic [31:0] exp_data);
    vec_t v;
    v.name = name; v.a = a; v.wd = wd; v.rd = rd; v.wr = wr;
    v.sz = sz; v.uns = uns; v.exp_err = exp_err; v.exp_data = exp_data;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver: present a request for one edge, return #1 after it
  task automatic issue(input logic [ADDR_W-1:0] a, input logic [31:0] wd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic uns);
    addr = a; write_data = wd; MemRead = rd; MemWrite = wr; size = sz; load_unsigned = uns;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // count sampled busy cycles from now; requests held by caller are ignored
  task automatic wait_clear(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      check("clear_no_valid", {31'b0, read_valid}, 32'h0);
      check("clear_no_err", {31'b0, access_err}, 32'h0);
      @(posedge clk); #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic read_all_zero(input int nwords, input string name);
    for (int i = 0; i < nwords; i++) begin
      issue(ADDR_W'(4 * i), 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      check({name, "_valid"}, {31'b0, read_valid}, 32'h1);
      check({name, "_data"}, read_data, 32'h0);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] last_data;

    // reset: two cycles
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'h1);
    check("reset_read_data", read_data, 32'h0);
    check("reset_read_valid", {31'b0, read_valid}, 32'h0);
    check("reset_access_err", {31'b0, access_err}, 32'h0);

    // clear sequence with a store/load held against it the whole time
    addr = '0; write_data = 32'hDEADBEEF; size = 2'b10; MemWrite = 1'b1; MemRead = 1'b1;
    reset = 1'b0;
    wait_clear(cyc);
    check("clear_busy_cycles", cyc, 64);
    check("clear_busy_low", {31'b0, busy}, 32'h0);
    check("clear_end_no_valid", {31'b0, read_valid}, 32'h0);
    read_all_zero(DEPTH, "clear_read");

    // directed vectors (sz: 0 byte, 1 half, 2 word, 3 reserved)
    add_vec("w_word10",   9'h010, 32'h11223344, 0, 1, 2'd2, 0, 0, 32'h0);
    add_vec("w_byte11",   9'h011, 32'h000000AA, 0, 1, 2'd0, 0, 0, 32'h0);
    add_vec("r_word10",   9'h010, 32'h0,        1, 0, 2'd2, 0, 0, 32'h1122AA44);
    add_vec("w_word20",   9'h020, 32'h8000FF80, 0, 1, 2'd2, 0, 0, 32'h0);
    add_vec("r_sbyte20",  9'h020, 32'h0,        1, 0, 2'd0, 0, 0, 32'hFFFFFF80);
    add_vec("r_ubyte20",  9'h020, 32'h0,        1, 0, 2'd0, 1, 0, 32'h00000080);
    add_vec("r_shalf22",  9'h022, 32'h0,        1, 0, 2'd1, 0, 0, 32'hFFFF8000);
    add_vec("r_uhalf22",  9'h022, 32'h0,        1, 0, 2'd1, 1, 0, 32'h00008000);
    add_vec("w_half21",   9'h021, 32'h0000BEEF, 0, 1, 2'd1, 0, 1, 32'h0);
    add_vec("r_word20",   9'h020, 32'h0,        1, 0, 2'd2, 0, 0, 32'h8000FF80);
    add_vec("r_half23",   9'h023, 32'h0,        1, 0, 2'd1, 0, 1, 32'h0);
    add_vec("r_word102",  9'h102, 32'h0,        1, 0, 2'd2, 0, 1, 32'h0);
    add_vec("r_word100",  9'h100, 32'h0,        1, 0, 2'd2, 0, 1, 32'h0);
    add_vec("w_rsvd24",   9'h024, 32'hCAFEF00D, 0, 1, 2'd3, 0, 1, 32'h0);
    add_vec("r_rsvd24",   9'h024, 32'h0,        1, 0, 2'd3, 0, 1, 32'h0);
    add_vec("w_half26",   9'h026, 32'h00001234, 0, 1, 2'd1, 0, 0, 32'h0);
    add_vec("r_word24",   9'h024, 32'h0,        1, 0, 2'd2, 0, 0, 32'h12340000);
    add_vec("r_sbyte27",  9'h027, 32'h0,        1, 0, 2'd0, 0, 0, 32'h00000012);
    add_vec("r_sbyte13",  9'h013, 32'h0,        1, 0, 2'd0, 0, 0, 32'h00000011);
    add_vec("r_uhalf12",  9'h012, 32'h0,        1, 0, 2'd1, 1, 0, 32'h00001122);
    add_vec("r_sbyte11",  9'h011, 32'h0,        1, 0, 2'd0, 0, 0, 32'hFFFFFFAA);
    add_vec("w_word30",   9'h030, 32'h00000005, 0, 1, 2'd2, 0, 0, 32'h0);
    add_vec("rw_word30",  9'h030, 32'h00000009, 1, 1, 2'd2, 0, 0, 32'h00000005);
    add_vec("r_word30",   9'h030, 32'h0,        1, 0, 2'd2, 0, 0, 32'h00000009);
    add_vec("w_byte33",   9'h033, 32'h0000007F, 0, 1, 2'd0, 0, 0, 32'h0);
    add_vec("r_word30b",  9'h030, 32'h0,        1, 0, 2'd2, 0, 0, 32'h7F000009);

    last_data = read_data;
    for (int i = 0; i < vq.size(); i++) begin
      issue(vq[i].a, vq[i].wd, vq[i].rd, vq[i].wr, vq[i].sz, vq[i].uns);
      if (vq[i].rd) last_data = vq[i].exp_data;
      check({vq[i].name, "_valid"}, {31'b0, read_valid}, {31'b0, vq[i].rd});
      check({vq[i].name, "_err"}, {31'b0, access_err}, {31'b0, vq[i].exp_err});
      check({vq[i].name, "_busy"}, {31'b0, busy}, 32'h0);
      check({vq[i].name, "_data"}, read_data, last_data);
    end

    // pulses drop on an idle cycle, data holds
    @(posedge clk); #1;
    check("idle_valid", {31'b0, read_valid}, 32'h0);
    check("idle_err", {31'b0, access_err}, 32'h0);
    check("idle_hold", read_data, last_data);

    // reset in the middle of a clear
    for (int i = 0; i < 40; i++) issue(ADDR_W'(4 * i), 32'(i + 1), 1'b0, 1'b1, 2'b10, 1'b0);
    issue(9'h014, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    check("prefill_word5", read_data, 32'h6);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    check("midclear_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midclear_reset_data", read_data, 32'h0);
    reset = 1'b0;
    wait_clear(cyc);
    check("midclear_busy_cycles", cyc, 64);
    read_all_zero(40, "midclear_read");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
